irq_ctrl: RTL and testbench

- Memory-mapped interrupt controller sitting directly upstream of the core's interrupt input; it replaces the constant-zero tie-off on the core's irq request.
- Collects up to NUM_IRQ peripheral interrupt lines (timer, uart, ...) and latches them as pending.
- Selects the highest-priority enabled pending source and presents it to the core as a one-hot request held until the core acknowledges.
- Tracks the in-service interrupt until software writes end-of-interrupt (EOI) over the shared data bus.

---
 rtl/irq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_irq_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped prioritised interrupt controller for the core.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on every source line.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ   = 8,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0300
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic [31:0]        irq_r_addr_i,
  input  logic [31:0]        irq_w_addr_i,
  input  logic [31:0]        irq_data_i,
  input  logic               irq_r_enable_i,
  input  logic               irq_w_enable_i,
  output logic [31:0]        irq_data_o,
  output logic [NUM_IRQ-1:0] irq_req_o,
  input  logic               irq_response_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_SVC  = 2'd2;

  logic [NUM_IRQ-1:0] src_s;
  logic [NUM_IRQ-1:0] src_d;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] en_q;
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] req_q;
  logic [1:0]         state_q;
  logic [4:0]         id_q;
  logic [31:0]        rdata_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q;
  logic [NUM_IRQ-1:0] sync2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src_i;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = irq_src_i;
`endif

  logic [31:0] r_off;
  logic [31:0] w_off;
  logic        r_hit;
  logic        w_hit;
  logic [2:0]  r_sel;
  logic [2:0]  w_sel;

  assign r_off = irq_r_addr_i - BASE_ADDR;
  assign w_off = irq_w_addr_i - BASE_ADDR;
  assign r_hit = r_off < 32'h14;
  assign w_hit = irq_w_enable_i && (w_off < 32'h14);
  assign r_sel = r_off[4:2];
  assign w_sel = w_off[4:2];

  logic wr_pend;
  logic wr_en;
  logic wr_edge;
  logic wr_eoi;

  assign wr_pend = w_hit && (w_sel == 3'd0);
  assign wr_en   = w_hit && (w_sel == 3'd1);
  assign wr_edge = w_hit && (w_sel == 3'd2);
  assign wr_eoi  = w_hit && (w_sel == 3'd4);

  logic               ack;
  logic [NUM_IRQ-1:0] wdata;
  logic [NUM_IRQ-1:0] id_oh;
  logic [NUM_IRQ-1:0] cand;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pend_nxt;

  assign ack   = (state_q == ST_REQ) && irq_response_i;
  assign wdata = irq_data_i[NUM_IRQ-1:0];
  assign id_oh = NUM_IRQ'(1) << id_q;
  assign cand  = pend_q & en_q;
  assign rise  = src_s & ~src_d;
  assign clr   = (wr_pend ? wdata : '0)
               | (ack ? id_oh : '0);

  // Edge bits: a new rise beats any clear in the same cycle.
  assign pend_nxt = (edge_q & (rise | (pend_q & ~clr)))
                  | (~edge_q & src_s);

  logic [4:0] win_id;

  always_comb begin
    win_id = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (cand[i]) win_id = 5'(i);
    end
  end

  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (r_hit) begin
      unique case (1'b1)
        r_sel == 3'd0: rd_mux[NUM_IRQ-1:0] = pend_q;
        r_sel == 3'd1: rd_mux[NUM_IRQ-1:0] = en_q;
        r_sel == 3'd2: rd_mux[NUM_IRQ-1:0] = edge_q;
        r_sel == 3'd3: rd_mux[9:0] = {
          state_q == ST_SVC,
          state_q == ST_REQ,
          3'b000,
          id_q
        };
        default: rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d   <= '0;
      pend_q  <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      req_q   <= '0;
      state_q <= ST_IDLE;
      id_q    <= '0;
      rdata_q <= '0;
    end else begin
      src_d   <= src_s;
      pend_q  <= pend_nxt;
      rdata_q <= irq_r_enable_i ? rd_mux : '0;
      if (wr_en) en_q <= wdata;
      if (wr_edge) edge_q <= wdata;
      unique case (state_q)
        ST_IDLE: begin
          if (|cand) begin
            id_q    <= win_id;
            req_q   <= NUM_IRQ'(1) << win_id;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (irq_response_i) begin
            req_q   <= '0;
            state_q <= ST_SVC;
          end
        end
        ST_SVC: begin
          if (wr_eoi) begin
            id_q    <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign irq_data_o = rdata_q;
  assign irq_req_o  = req_q;

  logic unused_bits;
  assign unused_bits = ^{irq_data_i, r_off[1:0], w_off[1:0]};

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed and random checks of irq_ctrl against a
// cycle model built from the register and FSM rules.
module tb_irq_ctrl;

  localparam int N = 8;
  localparam logic [31:0] BASE = 32'h8000_0300;
`ifdef IRQ_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int IDLE = 0;
  localparam int REQ  = 1;
  localparam int SVC  = 2;

  logic         clk;
  logic         rst;
  logic [N-1:0] irq_src_i;
  logic [31:0]  r_addr;
  logic [31:0]  w_addr;
  logic [31:0]  wdata;
  logic         ren;
  logic         wen;
  logic         resp;
  logic [31:0]  rdata;
  logic [N-1:0] req;

  irq_ctrl #(
    .NUM_IRQ  (N),
    .BASE_ADDR(BASE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .irq_src_i     (irq_src_i),
    .irq_r_addr_i  (r_addr),
    .irq_w_addr_i  (w_addr),
    .irq_data_i    (wdata),
    .irq_r_enable_i(ren),
    .irq_w_enable_i(wen),
    .irq_data_o    (rdata),
    .irq_req_o     (req),
    .irq_response_i(resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec;
  int nerr;

  bit [N-1:0] m_pend, m_en, m_edge, m_prev, m_req;
  bit [N-1:0] m_s1, m_s2;
  int         m_state;
  int         m_id;
  bit [31:0]  m_rdata;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend  = '0;
    m_en    = '0;
    m_edge  = '0;
    m_prev  = '0;
    m_req   = '0;
    m_s1    = '0;
    m_s2    = '0;
    m_state = IDLE;
    m_id    = 0;
    m_rdata = '0;
  endtask

  function automatic bit [31:0] m_read(input logic [31:0] a);
    bit [31:0] off;
    off = a - BASE;
    if (off >= 32'h14) return 32'd0;
    case (off / 4)
      0: return 32'(m_pend);
      1: return 32'(m_en);
      2: return 32'(m_edge);
      3: return 32'(m_id + (m_state == REQ ? 256 : 0)
                         + (m_state == SVC ? 512 : 0));
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge();
    bit [N-1:0] s;
    bit [N-1:0] np;
    bit [31:0]  woff;
    bit         whit;
    int         wreg;
    int         win;
`ifdef IRQ_SYNC_EN
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = irq_src_i;
`else
    s = irq_src_i;
`endif
    m_rdata = ren ? m_read(r_addr) : 32'd0;
    woff = w_addr - BASE;
    whit = wen && (woff < 32'h14);
    wreg = whit ? int'(woff / 4) : -1;
    for (int i = 0; i < N; i++) begin
      if (m_edge[i]) begin
        if (s[i] && !m_prev[i]) np[i] = 1'b1;
        else if ((wreg == 0 && wdata[i]) ||
                 (m_state == REQ && resp && m_id == i)) np[i] = 1'b0;
        else np[i] = m_pend[i];
      end else begin
        np[i] = s[i];
      end
    end
    win = -1;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i] && m_en[i]) win = i;
    case (m_state)
      IDLE: if (win >= 0) begin
        m_id = win;
        m_req = '0;
        m_req[win] = 1'b1;
        m_state = REQ;
      end
      REQ: if (resp) begin
        m_req = '0;
        m_state = SVC;
      end
      SVC: if (wreg == 4) begin
        m_id = 0;
        m_state = IDLE;
      end
      default: ;
    endcase
    if (wreg == 1) m_en = wdata[N-1:0];
    if (wreg == 2) m_edge = wdata[N-1:0];
    m_prev = s;
    m_pend = np;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_req", 32'(req), 32'(m_req));
    chk("model_rdata", rdata, m_rdata);
  endtask

  task automatic rd(input int k);
    r_addr = BASE + 32'(4 * k);
    ren = 1'b1;
    tick();
    ren = 1'b0;
  endtask

  task automatic wr(input int k, input logic [31:0] d);
    w_addr = BASE + 32'(4 * k);
    wdata = d;
    wen = 1'b1;
    tick();
    wen = 1'b0;
  endtask

  task automatic pulse_ack();
    resp = 1'b1;
    tick();
    resp = 1'b0;
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    irq_src_i = '0;
    r_addr = '0;
    w_addr = '0;
    wdata = '0;
    ren = 1'b0;
    wen = 1'b0;
    resp = 1'b0;
    model_reset();
    #12;
    rst = 1'b0;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    for (int k = 0; k < 5; k++) begin
      rd(k);
      chk("rst_reg", rdata, 32'd0);
    end
    tick();
    chk("rd_idle", rdata, 32'd0);

    // single edge source
    wr(1, 32'h1);
    wr(2, 32'h1);
    irq_src_i = 8'h01;
    tick();
    irq_src_i = 8'h00;
    repeat (SL) tick();
    rd(0);
    chk("edge_pend", rdata, 32'h1);
    chk("edge_req", 32'(req), 32'h01);
    pulse_ack();
    chk("ack_req", 32'(req), 32'h0);
    rd(0);
    chk("ack_pend", rdata, 32'h0);
    rd(3);
    chk("svc_status", rdata, 32'h200);
    wr(4, 32'h0);
    rd(3);
    chk("eoi_status", rdata, 32'h0);

    // level sources, priority and re-request
    wr(2, 32'h0);
    wr(1, 32'hFF);
    irq_src_i = 8'h24;
    repeat (2 + SL) tick();
    chk("lvl_req", 32'(req), 32'h04);
    pulse_ack();
    wr(4, 32'h0);
    tick();
    chk("lvl_rereq", 32'(req), 32'h04);
    irq_src_i = 8'h20;
    repeat (1 + SL) tick();
    pulse_ack();
    wr(4, 32'h0);
    tick();
    chk("lvl_next", 32'(req), 32'h20);
    pulse_ack();
    irq_src_i = 8'h00;
    repeat (1 + SL) tick();
    wr(4, 32'h0);
    tick();
    chk("lvl_quiet", 32'(req), 32'h0);

    // W1C colliding with a new rising edge
    wr(1, 32'h8);
    wr(2, 32'h8);
    irq_src_i = 8'h08;
    repeat (2 + SL) tick();
    chk("e3_req", 32'(req), 32'h08);
    irq_src_i = 8'h00;
    pulse_ack();
    irq_src_i = 8'h08;
    repeat (SL) tick();
    wr(0, 32'h8);
    rd(0);
    chk("w1c_setwins", rdata, 32'h8);
    wr(0, 32'h8);
    rd(0);
    chk("w1c_clear", rdata, 32'h0);
    irq_src_i = 8'h00;
    wr(4, 32'h0);
    tick();
    chk("e3_done", 32'(req), 32'h0);

    // request held while source drops and enable clears
    wr(2, 32'h0);
    wr(1, 32'h2);
    irq_src_i = 8'h02;
    repeat (2 + SL) tick();
    chk("hold_req", 32'(req), 32'h02);
    wr(1, 32'h0);
    irq_src_i = 8'h00;
    repeat (4) tick();
    chk("hold_still", 32'(req), 32'h02);
    pulse_ack();
    chk("hold_ack", 32'(req), 32'h0);
    pulse_ack();
    rd(3);
    chk("svc_ignack", rdata, 32'h201);
    wr(4, 32'h0);
    rd(3);
    chk("idle_status", rdata, 32'h0);
    wr(4, 32'h0);
    pulse_ack();
    rd(3);
    chk("idle_ign", rdata, 32'h0);

    // asynchronous reset in the middle of a request
    wr(1, 32'h1);
    wr(2, 32'h1);
    irq_src_i = 8'h01;
    tick();
    irq_src_i = 8'h00;
    repeat (1 + SL) tick();
    chk("pre_rst_req", 32'(req), 32'h01);
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_req", 32'(req), 32'h0);
    chk("async_rdata", rdata, 32'h0);
    #1;
    rst = 1'b0;
    rd(1);
    chk("rst_en", rdata, 32'h0);
    rd(0);
    chk("rst_pend", rdata, 32'h0);
    rd(2);
    chk("rst_edge", rdata, 32'h0);

    // random traffic against the model
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src_i = N'($urandom);
      ren = 1'($urandom);
      if ($urandom_range(0, 7) == 0) r_addr = BASE - 32'd4;
      else r_addr = BASE + 32'(4 * $urandom_range(0, 6));
      wen = ($urandom_range(0, 3) == 0);
      w_addr = BASE + 32'(4 * $urandom_range(0, 5));
      wdata = $urandom;
      resp = ($urandom_range(0, 3) == 0);
      tick();
    end
    ren = 1'b0;
    wen = 1'b0;
    resp = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
